spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_peripheral.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI Mode 0 slave with byte-wide valid/ready tx and rx sides
//
// Purpose: an SPI slave clocked entirely by clk. The raw SPI pins are
// oversampled through SYNC_STAGES-flop synchronizers. Bytes are shifted
// MSB first and may run back to back within one select period. The tx side
// has a one-entry holding buffer.
//
// Parameter: SYNC_STAGES (2..3) sets the synchronizer depth.
// Optional feature: SPI_PERIPHERAL_OVERRUN_EN adds a sticky overrun flag.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   SPI_CLK/EN/MOSI/MISO   SPI pins (EN active low)
//   tx_data/valid/ready    byte to return to the master
//   rx_data/valid/ready    last complete byte received
//   busy                   a frame is in progress
//   overrun, overrun_clr   sticky drop flag and its clear (macro only)
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_CLK,
  input  logic       SPI_EN,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  ,
  output logic       overrun,
  input  logic       overrun_clr
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, en_sync_q, mosi_sync_q;
  logic       sclk_prev_q, en_prev_q;
  logic [2:0] fill_q;
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0] cur_q, cur_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic       cur_v_q, cur_v_d, hold_v_q, hold_v_d;
  logic       done_q, done_d, rx_valid_q, rx_valid_d;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic       overrun_q, overrun_d;
`endif

  logic sclk_s, en_s, mosi_s, filled;
  logic sclk_rise, sclk_fall, en_fall, en_rise;
  logic reload, restore;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign en_s   = en_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // After reset the synchronizers hold their reset values, not real pin
  // samples. Edges are ignored until the pipe and the previous-value flops
  // have been refilled. A select that was already low at reset therefore
  // never looks like a fresh falling edge.
  assign filled    = (fill_q == 3'(SYNC_STAGES + 1));
  assign sclk_rise = filled &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = filled & ~sclk_s &  sclk_prev_q;
  assign en_fall   = filled & ~en_s   &  en_prev_q;
  assign en_rise   = filled &  en_s   & ~en_prev_q;

  // A byte taken from the buffer but not fully shifted out is handed back
  // on deselect. The buffer is blocked for that cycle so the two writes
  // never collide.
  assign restore  = (state_q == ACTIVE) && en_rise && (bit_cnt_q != 4'd8) &&
                    cur_v_q && !hold_v_q;
  assign tx_ready = ~hold_v_q & ~restore;
  assign SPI_MISO = (state_q == ACTIVE) & tx_shift_q[7];
  assign busy     = (state_q == ACTIVE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  assign overrun  = overrun_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      en_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      en_prev_q   <= 1'b1;
      fill_q      <= 3'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], SPI_EN};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_prev_q <= sclk_s;
      en_prev_q   <= en_s;
      if (!filled) fill_q <= fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      cur_q      <= 8'h00;
      cur_v_q    <= 1'b0;
      hold_q     <= 8'h00;
      hold_v_q   <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      cur_q      <= cur_d;
      cur_v_q    <= cur_v_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    cur_d      = cur_q;
    cur_v_d    = cur_v_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    overrun_d  = overrun_q;
`endif
    reload     = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_fall) begin
          state_d   = ACTIVE;
          reload    = 1'b1;
          bit_cnt_d = 4'd0;
        end
      end
      ACTIVE: begin
        if (en_rise) begin
          state_d = IDLE;
        end else if (sclk_rise && bit_cnt_q != 4'd8) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          done_d     = (bit_cnt_q == 4'd7);
        end else if (sclk_fall) begin
          if (bit_cnt_q == 4'd8) begin
            reload    = 1'b1;
            bit_cnt_d = 4'd0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      tx_shift_d = hold_v_q ? hold_q : 8'h00;
      cur_d      = hold_v_q ? hold_q : 8'h00;
      cur_v_d    = hold_v_q;
      hold_v_d   = 1'b0;
    end
    if (restore) begin
      hold_d   = cur_q;
      hold_v_d = 1'b1;
    end
    // tx_ready implies the buffer was empty, so a same-cycle reload took
    // 8'h00 and the new byte waits in the buffer for the next reload.
    if (tx_valid && tx_ready) begin
      hold_d   = tx_data;
      hold_v_d = 1'b1;
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    if (overrun_clr) overrun_d = 1'b0;
    if (done_q) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
`else
    if (done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard bench for spi_peripheral with a behavioural SPI master
module tb_spi_peripheral;
  localparam int S = 2;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SPI_CLK = 1'b0, SPI_EN = 1'b1, SPI_MOSI = 1'b0;
  logic       SPI_MISO;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       busy;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic       overrun;
  logic       overrun_clr = 1'b0;
`endif

  spi_peripheral #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy)
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    ,
    .overrun(overrun), .overrun_clr(overrun_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise8_cyc = 0;
  logic lat_arm = 1'b0;
  logic rxv_prev = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];
  logic [7:0] mo_arr[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT hands over a byte or the
  // master finishes receiving one.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
      else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
    end
    if (got_miso.size() > 0) begin
      if (exp_miso.size() == 0) chk("miso_unexpected", {24'd0, got_miso.pop_front()}, 32'hFFFF_FFFF);
      else chk("miso_byte", {24'd0, got_miso.pop_front()}, {24'd0, exp_miso.pop_front()});
    end
    if (lat_arm && rx_valid && !rxv_prev) begin
      chk("rx_latency", cyc - rise8_cyc, S + 2);
      lat_arm = 1'b0;
    end
    rxv_prev = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 200) begin tick(1); t++; end
    chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data = b; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits);
    logic [7:0] mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = mo[7-i];
      tick(H);
      mi = {mi[6:0], SPI_MISO};
      SPI_CLK = 1'b1;
      if (i == 7) rise8_cyc = cyc;
      tick(H);
      SPI_CLK = 1'b0;
    end
    if (nbits == 8) got_miso.push_back(mi);
  endtask

  task automatic frame(input int nbytes, input int last_bits, input logic mid_en, input logic [7:0] mid);
    SPI_EN = 1'b0;
    tick(8);
    if (mid_en) load(mid);
    for (int k = 0; k < nbytes; k++) xfer(mo_arr[k], (k == nbytes - 1) ? last_bits : 8);
    tick(H);
    SPI_EN = 1'b1;
    tick(12);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_rx.size() != 0 || got_miso.size() != 0) && t < 200) begin tick(1); t++; end
    chk("drain", exp_rx.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hits;
    int n;
    logic pre, mid;
    logic [7:0] p, m;

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_miso", {31'd0, SPI_MISO}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 1);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    chk("rst_overrun", {31'd0, overrun}, 0);
`endif

    // Preloaded A5, master sends 3C, rx held until rx_ready.
    rx_ready = 1'b0;
    load(8'hA5);
    chk("tx_ready_full", {31'd0, tx_ready}, 0);
    exp_miso.push_back(8'hA5); exp_rx.push_back(8'h3C);
    mo_arr[0] = 8'h3C; lat_arm = 1'b1;
    frame(1, 8, 1'b0, 8'h00);
    tick(20);
    chk("rx_held_valid", {31'd0, rx_valid}, 1);
    chk("rx_held_data", {24'd0, rx_data}, 32'h3C);
    rx_ready = 1'b1;
    drain();
    chk("rx_valid_clr", {31'd0, rx_valid}, 0);

    // Two bytes in one select with a mid-frame load.
    load(8'h12);
    exp_miso.push_back(8'h12); exp_miso.push_back(8'h34);
    exp_rx.push_back(8'hF0); exp_rx.push_back(8'h0F);
    mo_arr[0] = 8'hF0; mo_arr[1] = 8'h0F;
    frame(2, 8, 1'b1, 8'h34);
    drain();

    // Empty buffer returns 00.
    exp_miso.push_back(8'h00); exp_rx.push_back(8'h55);
    mo_arr[0] = 8'h55;
    frame(1, 8, 1'b0, 8'h00);
    drain();

    // Partial frame keeps the buffered byte for the next frame.
    load(8'hC3);
    mo_arr[0] = 8'hFF;
    frame(1, 5, 1'b0, 8'h00);
    chk("partial_keeps_buf", {31'd0, tx_ready}, 0);
    chk("partial_no_rx", {31'd0, rx_valid}, 0);
    exp_miso.push_back(8'hC3); exp_rx.push_back(8'h81);
    mo_arr[0] = 8'h81;
    frame(1, 8, 1'b0, 8'h00);
    drain();
    chk("partial_rx_data", {24'd0, rx_data}, 32'h81);

    // Second byte arrives while the first is still unconsumed.
    rx_ready = 1'b0;
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    mo_arr[0] = 8'h11; mo_arr[1] = 8'h22;
    frame(2, 8, 1'b0, 8'h00);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    chk("ovr_rx_data", {24'd0, rx_data}, 32'h11);
    chk("ovr_set", {31'd0, overrun}, 1);
    overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 0);
    exp_rx.push_back(8'h11);
`else
    chk("ovw_rx_data", {24'd0, rx_data}, 32'h22);
    chk("ovw_rx_valid", {31'd0, rx_valid}, 1);
    exp_rx.push_back(8'h22);
`endif
    rx_ready = 1'b1;
    drain();

    // Random frames against the rule-level model.
    for (int f = 0; f < 8; f++) begin
      n   = $urandom_range(1, 3);
      pre = 1'($urandom_range(0, 1));
      p   = 8'($urandom);
      mid = (n >= 2) && ($urandom_range(0, 1) == 1);
      m   = 8'($urandom);
      if (pre) load(p);
      for (int k = 0; k < n; k++) begin
        mo_arr[k] = 8'($urandom);
        exp_rx.push_back(mo_arr[k]);
        if (k == 0) exp_miso.push_back(pre ? p : 8'h00);
        else if (k == 1) exp_miso.push_back(mid ? m : 8'h00);
        else exp_miso.push_back(8'h00);
      end
      frame(n, 8, mid, m);
      drain();
    end

    // Reset mid-frame with select held low.
    SPI_EN = 1'b0;
    tick(8);
    xfer(8'hAA, 4);
    rst = 1'b1; tick(1); rst = 1'b0;
    busy_hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy) busy_hits++;
    end
    chk("rst_mid_busy", busy_hits, 0);
    chk("rst_mid_miso", {31'd0, SPI_MISO}, 0);
    chk("rst_mid_tx_ready", {31'd0, tx_ready}, 1);
    chk("rst_mid_rx_data", {24'd0, rx_data}, 0);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 0);
    SPI_EN = 1'b1; tick(10);
    SPI_EN = 1'b0;
    n = 0;
    while (!busy && n < 50) begin tick(1); n++; end
    chk("reselect_busy", {31'd0, busy}, 1);
    SPI_EN = 1'b1; tick(10);

    chk("exp_rx_empty", exp_rx.size(), 0);
    chk("exp_miso_empty", exp_miso.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
